sram_req_queue: RTL and testbench
=================================

Name: sram_req_queue

Overview:
- Request-side front end placed directly upstream of the SRAM word interface (addr/drw/din/dout/rdy port set).
- Accepts 32-bit read/write requests from the CPU/bus side over valid/ready and buffers them in a small FIFO.
- Launches each request into the SRAM interface only on a cycle where that interface reports rdy, and holds the request stable for the whole access.
- Captures read data on completion and returns it over a valid/ready response channel.

Parameters:
- DEPTH, 4, request FIFO entries; power of 2, ≥2.
- AW, 32, address width.
- DW, 32, data width; fixed 32 to match the SRAM interface.

Ports:
- clk  in  1  system clock.
- rst  in  1  asynchronous reset, active-low.
- req_valid  in  1  request offered.
- req_ready  out  1  FIFO can accept a request.
- req_addr  in  AW  byte address; bits [1:0] are ignored downstream.
- req_we  in  1  1 = write, 0 = read.
- req_wdata  in  DW  write data.
- rsp_valid  out  1  read data available.
- rsp_ready  in  1  consumer accepts read data.
- rsp_rdata  out  DW  read data.
- mem_addr  out  AW  to SRAM interface addr; registered.
- mem_drw  out  1  to SRAM interface drw; combinational, see Behaviour.
- mem_din  out  DW  to SRAM interface din; registered.
- mem_dout  in  DW  from SRAM interface dout.
- mem_rdy  in  1  from SRAM interface rdy; 1 = interface in its start cycle.

Behaviour:
- Reset (rst=0, asynchronous):
  - FIFO empty; state=IDLE.
  - req_ready=0 while rst asserted, 1 after release.
  - rsp_valid=0, rsp_rdata=0, mem_addr=0, mem_din=0, mem_drw=0.
- Downstream property relied on: the SRAM interface runs continuously. Every mem_rdy=1 cycle starts an access using the mem_drw/mem_addr/mem_din present in that cycle. Read = 5 cycles, write = 6 cycles, until the next mem_rdy=1. When mem_drw=0 the interface performs idle reads, which are harmless.
- FIFO:
  - Push when req_valid & req_ready.
  - req_ready = (count != DEPTH), with no same-cycle bypass at full.
  - No bypass when empty: a pushed request is visible to the FSM the next cycle.
- FSM states: IDLE, ARMED, BUSY.
  - IDLE → ARMED when FIFO non-empty and rsp_valid=0. On that edge, pop the head into mem_addr/mem_din/we_q.
  - ARMED → BUSY on mem_rdy=1 (launch cycle).
  - BUSY → IDLE on mem_rdy=1 (completion cycle). If we_q=0, load rsp_rdata←mem_dout and set rsp_valid=1 on that edge.
- mem_drw = we_q & ((ARMED & mem_rdy) | (BUSY & !mem_rdy)).
  - Write strobe is never driven mid idle-read or in the completion cycle, so no duplicate or partial write occurs.
- mem_addr/mem_din change only on the IDLE→ARMED edge, so they are stable from launch through completion.
- Response channel:
  - rsp_valid held until rsp_ready; cleared on the handshake edge.
  - Writes produce no response.
  - A new launch is blocked while rsp_valid=1, so at most one read is outstanding and responses stay in order.
- Latency: a read accepted into an empty, idle system returns rsp_valid at most 1 (push) + 1 (arm) + ≤5 (wait for rdy) + 5 (access) cycles later.
- Reset mid-access: state and outputs return to reset values immediately and mem_drw drops combinationally. The SRAM interface is reset by the same system reset domain, and in-flight requests are discarded.

Optional Feature:
- Macro: SRAM_REQ_STATS_EN.
- Defined:
  - Adds 32-bit output ports stat_rd_cnt and stat_wr_cnt. Each increments on the completion edge of a read or write respectively, wraps at 2^32, and resets to 0.
  - Adds 16-bit stat_stall_cnt, incremented each cycle req_valid=1 and req_ready=0; saturates at 0xFFFF.
- Undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Package sram_req_pkg holds:
  - typedef sram_req_t {addr[AW-1:0], we, wdata[DW-1:0]};
  - enum sram_req_state_e {IDLE, ARMED, BUSY};
  - constants SRAM_RD_CYCLES=5 and SRAM_WR_CYCLES=6 for the bench.
- One sub-module: sram_req_fifo. Synchronous FIFO of sram_req_t, DEPTH entries, with push/pop/full/empty/count and asynchronous active-low reset.

Test Plan:
- Single write: req addr=0x0000_1000, we=1, wdata=0xDEAD_BEEF.
  - Expect mem_drw=1 for exactly 6 consecutive cycles starting at the launch mem_rdy cycle.
  - mem_addr/mem_din are constant throughout; no rsp_valid.
- Read after write to 0x1000, using an SRAM interface + memory model.
  - rsp_rdata=0xDEAD_BEEF with rsp_valid asserted one cycle after the completion mem_rdy.
  - mem_drw stays 0 throughout the read.
- Fill: 5 pushes with DEPTH=4 while the FSM is stalled by rsp_valid=1 and rsp_ready=0.
  - req_ready=0 after the 4th accept.
  - The 5th is accepted only after a pop; no loss; reads return in order.
- Response backpressure: rsp_ready=0 for 20 cycles with 2 reads queued.
  - rsp_rdata is held stable and the second read is not launched (mem_drw=0, state IDLE) until the handshake.
- Arm mid idle-read: request arrives when the interface is in its 3rd cycle.
  - mem_drw stays 0 until the next mem_rdy=1, then the write launches.
- Reset during BUSY write: rst=0 in the 3rd write cycle.
  - mem_drw=0 in the same cycle, all outputs at reset values, FIFO empty after release.

Source files
------------

// File: rtl/sram_req_pkg.sv
// Shared types and constants for the SRAM request queue.
// Optional statistics counters are enabled with the SRAM_REQ_STATS_EN macro.
package sram_req_pkg;

    localparam int SRAM_AW        = 32;
    localparam int SRAM_DW        = 32;
    localparam int SRAM_RD_CYCLES = 5;
    localparam int SRAM_WR_CYCLES = 6;

    typedef struct packed {
        logic [SRAM_AW-1:0] addr;
        logic               we;
        logic [SRAM_DW-1:0] wdata;
    } sram_req_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        BUSY  = 2'd2
    } sram_req_state_e;

endpackage

// File: rtl/sram_req_queue_if.sv
// Bundle of the request, response and SRAM-side signals of the request queue.
// The slave modport is the queue's view; the master modport is the surroundings.
interface sram_req_queue_if #(
    parameter int AW = 32,
    parameter int DW = 32
);

    logic          req_valid;
    logic          req_ready;
    logic [AW-1:0] req_addr;
    logic          req_we;
    logic [DW-1:0] req_wdata;

    logic          rsp_valid;
    logic          rsp_ready;
    logic [DW-1:0] rsp_rdata;

    logic [AW-1:0] mem_addr;
    logic          mem_drw;
    logic [DW-1:0] mem_din;
    logic [DW-1:0] mem_dout;
    logic          mem_rdy;

    modport slave (
        input  req_valid, req_addr, req_we, req_wdata, rsp_ready, mem_dout, mem_rdy,
        output req_ready, rsp_valid, rsp_rdata, mem_addr, mem_drw, mem_din
    );

    modport master (
        output req_valid, req_addr, req_we, req_wdata, rsp_ready, mem_dout, mem_rdy,
        input  req_ready, rsp_valid, rsp_rdata, mem_addr, mem_drw, mem_din
    );

endinterface

// File: rtl/sram_req_fifo.sv
// Small synchronous FIFO holding pending SRAM requests.
// The head entry is always visible on 'head'; pushes at full and pops at empty are ignored.
module sram_req_fifo
    import sram_req_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  sram_req_t     push_data,
    input  logic          pop,
    output sram_req_t     head,
    output logic          full,
    output logic          empty,
    output logic [CW-1:0] count
);

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    sram_req_t     mem_q [DEPTH];
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem_q[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Entry storage needs no reset because empty slots are never read as valid.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/sram_req_queue.sv
// Request front end for the continuously running SRAM word interface.
// Buffers requests, launches one per interface start cycle and returns read data.
// Optional macro SRAM_REQ_STATS_EN adds read/write/stall statistics outputs.
module sram_req_queue
    import sram_req_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = SRAM_AW,
    parameter int DW    = SRAM_DW
) (
    input  logic                  clk,
    input  logic                  rst,
    sram_req_queue_if.slave       bus
`ifdef SRAM_REQ_STATS_EN
    ,
    output logic [31:0]           stat_rd_cnt,
    output logic [31:0]           stat_wr_cnt,
    output logic [15:0]           stat_stall_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    sram_req_state_e state_q;
    sram_req_state_e state_d;

    sram_req_t       push_data;
    sram_req_t       head;
    logic            push;
    logic            pop;
    logic            fifo_empty;
    logic            fifo_full_unused;
    logic [CW-1:0]   fifo_count;

    logic [AW-1:0]   mem_addr_q;
    logic [DW-1:0]   mem_din_q;
    logic            we_q;
    logic            rsp_valid_q;
    logic [DW-1:0]   rsp_rdata_q;
    logic            complete;

    // Ready is held low while reset is asserted so nothing is accepted into a resetting FIFO.
    assign bus.req_ready = rst & (fifo_count != CW'(DEPTH));
    assign push          = bus.req_valid & bus.req_ready;
    assign push_data     = '{addr: bus.req_addr, we: bus.req_we, wdata: bus.req_wdata};

    // A new request is only armed when no read response is waiting, keeping one read in flight.
    assign pop      = (state_q == IDLE) & ~fifo_empty & ~rsp_valid_q;
    assign complete = (state_q == BUSY) & bus.mem_rdy;

    sram_req_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .head      (head),
        .full      (fifo_full_unused),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    // Write strobe covers exactly the launch cycle plus the remaining write cycles, never the completion cycle.
    assign bus.mem_drw   = we_q & (((state_q == ARMED) & bus.mem_rdy) | ((state_q == BUSY) & ~bus.mem_rdy));
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_din   = mem_din_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_rdata = rsp_rdata_q;

    // Next-state logic: wait for an interface start cycle to launch, and the next one to complete.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (pop)         state_d = ARMED;
            ARMED:   if (bus.mem_rdy) state_d = BUSY;
            BUSY:    if (bus.mem_rdy) state_d = IDLE;
            default:                  state_d = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // Request registers load only when arming, so address and data stay stable for the whole access.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem_addr_q <= '0;
            mem_din_q  <= '0;
            we_q       <= 1'b0;
        end else if (pop) begin
            mem_addr_q <= head.addr;
            mem_din_q  <= head.wdata;
            we_q       <= head.we;
        end
    end

    // Read data is captured on the completion cycle and held until the consumer takes it.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else if (complete && !we_q) begin
            rsp_valid_q <= 1'b1;
            rsp_rdata_q <= bus.mem_dout;
        end else if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_q <= 1'b0;
        end
    end

`ifdef SRAM_REQ_STATS_EN
    // Completion counters wrap; the stall counter saturates so long stalls stay visible.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stat_rd_cnt    <= '0;
            stat_wr_cnt    <= '0;
            stat_stall_cnt <= '0;
        end else begin
            if (complete && !we_q) stat_rd_cnt <= stat_rd_cnt + 1'b1;
            if (complete && we_q)  stat_wr_cnt <= stat_wr_cnt + 1'b1;
            if (bus.req_valid && !bus.req_ready && (stat_stall_cnt != 16'hFFFF))
                stat_stall_cnt <= stat_stall_cnt + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_sram_req_queue.sv
// Self-checking bench for sram_req_queue with a continuously running SRAM interface model.
module tb_sram_req_queue;
    import sram_req_pkg::*;

    logic clk;
    logic rst;

    sram_req_queue_if #(.AW(32), .DW(32)) bus ();

`ifdef SRAM_REQ_STATS_EN
    logic [31:0] stat_rd_cnt;
    logic [31:0] stat_wr_cnt;
    logic [15:0] stat_stall_cnt;
`endif

    sram_req_queue #(.DEPTH(4), .AW(32), .DW(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
`ifdef SRAM_REQ_STATS_EN
        ,
        .stat_rd_cnt    (stat_rd_cnt),
        .stat_wr_cnt    (stat_wr_cnt),
        .stat_stall_cnt (stat_stall_cnt)
`endif
    );

    int compared   = 0;
    int mismatched = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // SRAM interface model: free-running accesses, 5 cycles per read and 6 per write.
    int          sram_cnt;
    logic [31:0] sram_mem [256];
    logic [31:0] sram_dout;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            sram_cnt  <= 0;
            sram_dout <= '0;
            for (int i = 0; i < 256; i++) sram_mem[i] <= '0;
        end else if (sram_cnt == 0) begin
            if (bus.mem_drw) begin
                sram_mem[bus.mem_addr[9:2]] <= bus.mem_din;
                sram_cnt <= SRAM_WR_CYCLES - 1;
            end else begin
                sram_dout <= sram_mem[bus.mem_addr[9:2]];
                sram_cnt  <= SRAM_RD_CYCLES - 1;
            end
        end else begin
            sram_cnt <= sram_cnt - 1;
        end
    end

    assign bus.mem_rdy  = (sram_cnt == 0);
    assign bus.mem_dout = sram_dout;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected)
        else begin
            mismatched++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Reference model: word memory updated in request order, expected reads and writes in order.
    logic [31:0] ref_mem [256];
    logic [31:0] exp_rsp [$];
    logic [63:0] exp_wr  [$];
    logic [63:0] cur_wr;
    int          run_len     = 0;
    int          wr_pushed   = 0;
    int          wr_done     = 0;
    logic        prev_drw    = 1'b0;
    logic        prev_rdy    = 1'b0;
    logic        prev_rvalid = 1'b0;

    always @(negedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) ref_mem[i] = '0;
            exp_rsp.delete();
            exp_wr.delete();
            run_len     = 0;
            prev_drw    = 1'b0;
            prev_rdy    = 1'b0;
            prev_rvalid = 1'b0;
        end else begin
            if (bus.req_valid && bus.req_ready) begin
                if (bus.req_we) begin
                    ref_mem[bus.req_addr[9:2]] = bus.req_wdata;
                    exp_wr.push_back({bus.req_addr, bus.req_wdata});
                    wr_pushed++;
                end else begin
                    exp_rsp.push_back(ref_mem[bus.req_addr[9:2]]);
                end
            end
            if (bus.mem_drw && !prev_drw) begin
                checkOutput("drw_launch_on_rdy", 32'(bus.mem_rdy), 32'd1);
                if (exp_wr.size() == 0) begin
                    checkOutput("wr_unexpected", 32'(bus.mem_drw), 32'd0);
                end else begin
                    cur_wr  = exp_wr.pop_front();
                    run_len = 1;
                    checkOutput("wr_addr", bus.mem_addr, cur_wr[63:32]);
                    checkOutput("wr_din", bus.mem_din, cur_wr[31:0]);
                end
            end else if (bus.mem_drw) begin
                run_len++;
                checkOutput("wr_addr_stable", bus.mem_addr, cur_wr[63:32]);
                checkOutput("wr_din_stable", bus.mem_din, cur_wr[31:0]);
            end else if (prev_drw) begin
                checkOutput("wr_strobe_len", 32'(run_len), 32'(SRAM_WR_CYCLES));
                wr_done++;
                run_len = 0;
            end
            if (bus.rsp_valid && !prev_rvalid)
                checkOutput("rsp_after_completion", 32'(prev_rdy), 32'd1);
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (exp_rsp.size() == 0)
                    checkOutput("rsp_unexpected", 32'(bus.rsp_valid), 32'd0);
                else
                    checkOutput("rsp_rdata", bus.rsp_rdata, exp_rsp.pop_front());
            end
            prev_drw    = bus.mem_drw;
            prev_rdy    = bus.mem_rdy;
            prev_rvalid = bus.rsp_valid;
        end
    end

    // Random response backpressure used during the randomized phase.
    logic rnd_bp = 1'b0;
    always @(posedge clk) begin
        if (rnd_bp) begin
            #1 bus.rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    task automatic applyStimulus(input logic [31:0] addr, input logic we, input logic [31:0] wdata);
        int waited;
        @(posedge clk);
        #1;
        bus.req_addr  = addr;
        bus.req_we    = we;
        bus.req_wdata = wdata;
        bus.req_valid = 1'b1;
        waited = 0;
        @(negedge clk);
        while (!bus.req_ready && waited < 200) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("push_accept", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #1 bus.req_valid = 1'b0;
    endtask

    task automatic waitDrain();
        int waited;
        waited = 0;
        while ((exp_rsp.size() + exp_wr.size()) != 0 && waited < 3000) begin
            @(negedge clk);
            waited++;
        end
        repeat (15) @(negedge clk);
        checkOutput("drain", 32'(exp_rsp.size() + exp_wr.size()), 32'd0);
    endtask

    int base;
    int waited;

    initial begin
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_addr  = '0;
        bus.req_we    = 1'b0;
        bus.req_wdata = '0;
        bus.rsp_ready = 1'b1;

        // Reset values.
        repeat (2) @(negedge clk);
        checkOutput("rst_req_ready", 32'(bus.req_ready), 32'd0);
        checkOutput("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
        checkOutput("rst_mem_addr", bus.mem_addr, 32'd0);
        checkOutput("rst_mem_din", bus.mem_din, 32'd0);
        checkOutput("rst_mem_drw", 32'(bus.mem_drw), 32'd0);
        @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("ready_after_reset", 32'(bus.req_ready), 32'd1);

        // Single write: six strobe cycles, no response.
        $display("[TB] single write");
        base = wr_done;
        applyStimulus(32'h0000_1000, 1'b1, 32'hDEAD_BEEF);
        waited = 0;
        while (wr_done == base && waited < 40) begin
            @(negedge clk);
            checkOutput("wr_no_rsp", 32'(bus.rsp_valid), 32'd0);
            waited++;
        end
        checkOutput("wr_completed", 32'(wr_done), 32'(base + 1));

        // Read back the written word within the idle-system latency bound.
        $display("[TB] read after write");
        applyStimulus(32'h0000_1000, 1'b0, 32'h0);
        waited = 0;
        while (!bus.rsp_valid && waited < 12) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("raw_latency", 32'(bus.rsp_valid), 32'd1);
        checkOutput("raw_rdata", bus.rsp_rdata, 32'hDEAD_BEEF);
        waitDrain();

        // Fill the FIFO while a held response blocks launches.
        $display("[TB] fill");
        applyStimulus(32'h0000_0004, 1'b1, 32'h1111_1111);
        applyStimulus(32'h0000_0008, 1'b1, 32'h2222_2222);
        applyStimulus(32'h0000_000C, 1'b1, 32'h3333_3333);
        waitDrain();
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        applyStimulus(32'h0000_1000, 1'b0, 32'h0);
        waited = 0;
        while (!bus.rsp_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("fill_rsp_held", 32'(bus.rsp_valid), 32'd1);
        applyStimulus(32'h0000_0004, 1'b0, 32'h0);
        applyStimulus(32'h0000_0008, 1'b0, 32'h0);
        applyStimulus(32'h0000_000C, 1'b0, 32'h0);
        applyStimulus(32'h0000_0004, 1'b0, 32'h0);
        @(negedge clk);
        checkOutput("fill_full", 32'(bus.req_ready), 32'd0);
        fork
            applyStimulus(32'h0000_0008, 1'b0, 32'h0);
            begin
                repeat (3) begin
                    @(negedge clk);
                    checkOutput("fill_blocked", 32'(bus.req_ready), 32'd0);
                end
                @(posedge clk);
                #1 bus.rsp_ready = 1'b1;
            end
        join
        waitDrain();

        // Response backpressure with two reads queued.
        $display("[TB] response backpressure");
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        applyStimulus(32'h0000_0008, 1'b0, 32'h0);
        applyStimulus(32'h0000_000C, 1'b0, 32'h0);
        waited = 0;
        while (!bus.rsp_valid && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        repeat (20) begin
            @(negedge clk);
            checkOutput("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            checkOutput("bp_rdata_held", bus.rsp_rdata, 32'h2222_2222);
            checkOutput("bp_no_launch_addr", bus.mem_addr, 32'h0000_0008);
            checkOutput("bp_no_drw", 32'(bus.mem_drw), 32'd0);
        end
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        waitDrain();

        // Randomized traffic against the reference model.
        $display("[TB] random traffic");
        rnd_bp = 1'b1;
        for (int n = 0; n < 40; n++) begin
            applyStimulus(32'($urandom_range(0, 15)) << 2, 1'($urandom_range(0, 1)), $urandom);
            repeat ($urandom_range(0, 3)) @(posedge clk);
        end
        rnd_bp = 1'b0;
        repeat (2) @(posedge clk);
        #2 bus.rsp_ready = 1'b1;
        waitDrain();

        // Request arriving in the third cycle of an idle read must wait for the next start cycle.
        $display("[TB] arm mid idle-read");
        waited = 0;
        @(negedge clk);
        while (!bus.mem_rdy && waited < 10) begin
            @(negedge clk);
            waited++;
        end
        @(posedge clk);
        applyStimulus(32'h0000_0020, 1'b1, 32'hCAFE_F00D);
        waited = 0;
        while (waited < 10) begin
            @(negedge clk);
            waited++;
            if (bus.mem_rdy) break;
            checkOutput("arm_wait_no_drw", 32'(bus.mem_drw), 32'd0);
        end
        checkOutput("arm_launch_drw", 32'(bus.mem_drw), 32'd1);
        waitDrain();

        // Reset in the third cycle of a write access.
        $display("[TB] reset during write");
        applyStimulus(32'h0000_0040, 1'b1, 32'h5A5A_A5A5);
        waited = 0;
        @(negedge clk);
        while (!(bus.mem_drw && bus.mem_rdy) && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("rw_launch_seen", 32'(bus.mem_drw), 32'd1);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        checkOutput("rw_drw_drop", 32'(bus.mem_drw), 32'd0);
        checkOutput("rw_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        checkOutput("rw_rsp_rdata", bus.rsp_rdata, 32'd0);
        checkOutput("rw_mem_addr", bus.mem_addr, 32'd0);
        checkOutput("rw_mem_din", bus.mem_din, 32'd0);
        checkOutput("rw_req_ready", 32'(bus.req_ready), 32'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        checkOutput("rw_ready_after", 32'(bus.req_ready), 32'd1);
        repeat (3) @(negedge clk);
        checkOutput("rw_fifo_empty_no_drw", 32'(bus.mem_drw), 32'd0);
        applyStimulus(32'h0000_0040, 1'b0, 32'h0);
        waitDrain();

        checkOutput("write_count", 32'(wr_done), 32'(wr_pushed - 1));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
